// File: rtl/adc_pkg.sv
// Shared constants and FSM encoding for the ADC RAM readout path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adc_pkg;
    localparam int ADDR_W    = 12;
    localparam int DATA_W    = 32;
    localparam int RAM_DEPTH = 4096;
    localparam int SHIFT_W   = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_e;
endpackage

// File: rtl/readout_fifo.sv
// Small synchronous FIFO with occupancy count; push and pop may share a cycle.
// Latency: a pushed word is visible at head_dat the cycle after the push.
// Backpressure: push is dropped when full unless a pop frees the slot in the same cycle.
module readout_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_vld,
    input  logic [DATA_W-1:0] push_dat,
    input  logic              pop_rdy,
    output logic [DATA_W-1:0] head_dat,
    output logic              empty,
    output logic              full,
    output logic [CNT_W-1:0]  count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push;
    logic              pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign count    = count_q;
    assign head_dat = mem_q[rd_ptr_q];

    always_comb begin
        pop      = pop_rdy && !empty;
        push     = push_vld && (!full || pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the count alone decides what is visible.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: rtl/adc_ram_readout.sv
// Streams a window of the ADC sum RAM to the host, optionally shifting and clearing each word.
// Latency: first m_valid RD_LAT+2 cycles after start; one word per cycle when m_ready stays high.
// Backpressure: reads issue only while FIFO occupancy plus in-flight reads is below RD_LAT+2.
module adc_ram_readout #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic [4:0]        shift,
    input  logic              clear_en,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wr_data,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last
);
    import adc_pkg::*;

    localparam int FIFO_DEPTH = RD_LAT + 2;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int INF_W      = $clog2(RD_LAT + 1);

    typedef struct packed {
        logic              vld;
        logic [ADDR_W-1:0] addr;
    } rd_tag_t;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   issued_q, issued_d;
    logic [ADDR_W:0]   beat_q, beat_d;
    logic [4:0]        shift_q, shift_d;
    logic              clear_q, clear_d;
    rd_tag_t [RD_LAT-1:0] pipe_q, pipe_d;

    rd_tag_t           ret;
    logic [INF_W-1:0]  inflight;
    logic [CNT_W-1:0]  fifo_count;
    logic [DATA_W-1:0] fifo_head;
    logic              fifo_empty;
    logic              fifo_full;
    logic              issue;
    logic              beat_fire;
    logic              is_last;

    assign ret         = pipe_q[RD_LAT-1];
    assign ram_rd_addr = base_q + issued_q[ADDR_W-1:0];
    assign ram_wr_addr = ret.addr;
    assign ram_we      = ret.vld && clear_q;
    assign ram_wr_data = '0;

    assign m_valid   = !fifo_empty;
    assign m_data    = m_valid ? fifo_head : '0;
    assign is_last   = (beat_q == len_q - 1'b1);
    assign m_last    = m_valid && is_last;
    assign beat_fire = m_valid && m_ready;

    assign busy = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done = (state_q == ST_FIN);

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + INF_W'(pipe_q[i].vld);
        end
    end

    // Counting in-flight reads against free FIFO slots is what keeps the FIFO from overflowing.
    assign issue = (state_q == ST_RUN) &&
                   ((int'(fifo_count) + int'(inflight)) < FIFO_DEPTH);

    always_comb begin
        pipe_d[0].vld  = issue;
        pipe_d[0].addr = ram_rd_addr;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        len_d    = len_q;
        shift_d  = shift_q;
        clear_d  = clear_q;
        issued_d = issued_q;
        beat_d   = beat_q + (ADDR_W+1)'(beat_fire);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        state_d  = ST_RUN;
                        base_d   = base_addr;
                        len_d    = length;
                        shift_d  = shift;
                        clear_d  = clear_en;
                        issued_d = '0;
                        beat_d   = '0;
                    end else begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_RUN: begin
                if (issue) begin
                    issued_d = issued_q + 1'b1;
                    if (issued_q + 1'b1 == len_q) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (beat_fire && is_last && inflight == '0) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            base_q   <= '0;
            len_q    <= '0;
            shift_q  <= '0;
            clear_q  <= 1'b0;
            issued_q <= '0;
            beat_q   <= '0;
            pipe_q   <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            len_q    <= len_d;
            shift_q  <= shift_d;
            clear_q  <= clear_d;
            issued_q <= issued_d;
            beat_q   <= beat_d;
            pipe_q   <= pipe_d;
        end
    end

    readout_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (ret.vld),
        .push_dat (ram_rd_data >> shift_q),
        .pop_rdy  (m_ready),
        .head_dat (fifo_head),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .count    (fifo_count)
    );

    logic unused_full;
    assign unused_full = fifo_full;
endmodule

// File: tb/tb_adc_ram_readout.sv
// Randomised bench for adc_ram_readout with a queue-based reference model and RAM model.
// Latency: n/a. Backpressure: m_ready driven always-on, 1-in-4, or random.
module tb_adc_ram_readout;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 2;
    localparam int DEPTH  = RD_LAT + 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W:0]   length = '0;
    logic [4:0]        shift = '0;
    logic              clear_en = 1'b0;
    logic              busy, done, ram_we, m_valid, m_last;
    logic              m_ready = 1'b1;
    logic [ADDR_W-1:0] ram_rd_addr, ram_wr_addr;
    logic [DATA_W-1:0] ram_rd_data = '0;
    logic [DATA_W-1:0] ram_wr_data, m_data;

    logic [DATA_W-1:0] mem [4096];
    int                wr_cnt [4096];
    int                wr_total = 0;
    logic [DATA_W-1:0] rd_p1 = '0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rdy_mode = 0;

    // Reference model state
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] got_q[$];
    int                exp_len = 0;
    int                beat_idx = 0;
    int                start_cyc = 0;
    int                done_seen = 0;
    bit                model_active = 0;
    bit                model_clear = 0;
    bit                done_due = 0;
    bit                zero_pend = 0;
    bit                first_seen = 0;
    bit                prev_stall = 0;
    logic [DATA_W-1:0] prev_data = '0;
    logic [ADDR_W-1:0] run_base = '0;

    adc_ram_readout #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .base_addr   (base_addr),
        .length      (length),
        .shift       (shift),
        .clear_en    (clear_en),
        .busy        (busy),
        .done        (done),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data),
        .ram_wr_addr (ram_wr_addr),
        .ram_we      (ram_we),
        .ram_wr_data (ram_wr_data),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_last      (m_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Two-cycle registered-output RAM; clear writes land at the clock edge.
    always @(posedge clk) begin
        rd_p1       <= mem[ram_rd_addr];
        ram_rd_data <= rd_p1;
        if (ram_we) begin
            mem[ram_wr_addr] = ram_wr_data;
            wr_cnt[ram_wr_addr] = wr_cnt[ram_wr_addr] + 1;
            wr_total = wr_total + 1;
        end
    end

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = (cyc % 4 == 0);
            default: m_ready = ($urandom_range(0, 9) < 7);
        endcase
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 0;
        end else begin
            chk("done", done, done_due);
            if (done) done_seen++;
            done_due = 0;
            if (zero_pend) begin
                done_due  = 1;
                zero_pend = 0;
            end
            chk("busy", busy, model_active && (cyc > start_cyc));
            if (prev_stall) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_data", m_data, prev_data);
            end
            if (!model_active) chk("idle_valid", m_valid, 0);
            if (!m_valid) chk("last_without_valid", m_last, 0);
            if (ram_we) begin
                chk("wr_data_zero", ram_wr_data, 0);
                chk("wr_only_when_clear", model_clear && model_active, 1);
            end
            if (model_active && exp_len < 4096 && cyc > start_cyc) begin
                logic [ADDR_W-1:0] issued;
                issued = ram_rd_addr - run_base;
                chk("outstanding_le_depth", (int'(issued) - beat_idx) <= DEPTH, 1);
            end
            if (m_valid && model_active && exp_q.size() > 0) begin
                if (!first_seen) begin
                    chk("first_valid_latency", cyc - start_cyc, RD_LAT + 2);
                    first_seen = 1;
                end
                chk("m_last", m_last, beat_idx == exp_len - 1);
                chk("m_data", m_data, exp_q[0]);
                if (m_ready) begin
                    got_q.push_back(m_data);
                    void'(exp_q.pop_front());
                    beat_idx++;
                    if (beat_idx == exp_len) begin
                        model_active = 0;
                        done_due     = 1;
                    end
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    // Called just after a rising edge; the start pulse covers exactly one cycle.
    task automatic do_run(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] len,
                          input logic [4:0] sh, input logic cl);
        base_addr = b;
        length    = len;
        shift     = sh;
        clear_en  = cl;
        start     = 1'b1;
        if (!model_active && !done_due && !zero_pend) begin
            if (len == 0) begin
                zero_pend = 1;
            end else begin
                exp_q.delete();
                got_q.delete();
                for (int i = 0; i < int'(len); i++) begin
                    exp_q.push_back(mem[12'(int'(b) + i)] >> sh);
                end
                exp_len      = int'(len);
                beat_idx     = 0;
                run_base     = b;
                model_clear  = cl;
                first_seen   = 0;
                start_cyc    = cyc;
                model_active = 1;
            end
        end
        @(posedge clk);
        #1;
        start     = 1'b0;
        base_addr = ADDR_W'($urandom);
        length    = (ADDR_W+1)'($urandom);
        shift     = 5'($urandom);
        clear_en  = 1'($urandom);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((model_active || done_due || zero_pend) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (model_active || done_due || zero_pend) begin
            errors++;
            $display("FAIL run_timeout: beats %0d of %0d", beat_idx, exp_len);
            model_active = 0;
            done_due     = 0;
            zero_pend    = 0;
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic clear_wr_log();
        for (int i = 0; i < 4096; i++) wr_cnt[i] = 0;
        wr_total = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rd_addr"}, ram_rd_addr, 0);
        chk({tag, "_wr_addr"}, ram_wr_addr, 0);
        chk({tag, "_we"}, ram_we, 0);
        chk({tag, "_m_data"}, m_data, 0);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_m_last"}, m_last, 0);
    endtask

    task automatic check_cleared(input string tag, input logic [ADDR_W-1:0] b,
                                 input int len, input bit cl);
        int bad = 0;
        for (int i = 0; i < len; i++) begin
            if (cl && (wr_cnt[12'(int'(b) + i)] != 1 || mem[12'(int'(b) + i)] != 0)) bad++;
        end
        chk({tag, "_clear_addrs_bad"}, bad, 0);
        chk({tag, "_write_total"}, wr_total, cl ? len : 0);
    endtask

    logic [DATA_W-1:0] lit_basic [4];
    logic [DATA_W-1:0] lit_wrap [4];

    initial begin
        int bad;
        int d0;
        logic [ADDR_W-1:0] rb;
        logic [ADDR_W:0]   rl;
        logic [4:0]        rs;
        logic              rc;

        lit_basic = '{32'd30, 32'd33, 32'd36, 32'd39};
        lit_wrap  = '{32'h10, 32'h2, 32'h1, 32'h0FFF_FFFF};
        for (int i = 0; i < 4096; i++) mem[i] = 32'(i * 3);
        clear_wr_log();

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Basic readout
        do_run(12'd10, 13'd4, 5'd0, 1'b0);
        wait_idle(200);
        chk("basic_count", got_q.size(), 4);
        for (int i = 0; i < 4; i++) if (i < got_q.size()) chk("basic_beat", got_q[i], lit_basic[i]);
        bad = 0;
        for (int i = 0; i < 4096; i++) if (mem[i] != 32'(i * 3)) bad++;
        chk("basic_ram_unchanged", bad, 0);
        chk("basic_no_writes", wr_total, 0);

        // Wrap, shift and clear
        mem[4094] = 32'h100;
        mem[4095] = 32'h20;
        mem[0]    = 32'h1F;
        mem[1]    = 32'hFFFF_FFF0;
        clear_wr_log();
        do_run(12'd4094, 13'd4, 5'd4, 1'b1);
        wait_idle(200);
        chk("wrap_count", got_q.size(), 4);
        for (int i = 0; i < 4; i++) if (i < got_q.size()) chk("wrap_beat", got_q[i], lit_wrap[i]);
        chk("wrap_wr_4094", wr_cnt[4094], 1);
        chk("wrap_wr_4095", wr_cnt[4095], 1);
        chk("wrap_wr_0", wr_cnt[0], 1);
        chk("wrap_wr_1", wr_cnt[1], 1);
        chk("wrap_wr_total", wr_total, 4);

        // Backpressure 1-on/3-off
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        clear_wr_log();
        rdy_mode = 1;
        do_run(12'd100, 13'd16, 5'd0, 1'b0);
        wait_idle(1000);
        chk("bp_count", got_q.size(), 16);
        rdy_mode = 0;

        // Zero length, then a start while busy
        clear_wr_log();
        d0 = done_seen;
        do_run(12'd50, 13'd0, 5'd0, 1'b1);
        wait_idle(20);
        chk("zero_done_pulses", done_seen - d0, 1);
        chk("zero_no_writes", wr_total, 0);
        d0 = done_seen;
        do_run(12'd200, 13'd8, 5'd1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        do_run(12'd0, 13'd5, 5'd0, 1'b1);
        wait_idle(200);
        chk("ignored_start_count", got_q.size(), 8);
        chk("ignored_start_done", done_seen - d0, 1);
        chk("ignored_start_writes", wr_total, 0);

        // Full memory with clear
        clear_wr_log();
        do_run(12'd0, 13'd4096, 5'd0, 1'b1);
        wait_idle(6000);
        chk("full_count", got_q.size(), 4096);
        check_cleared("full", 12'd0, 4096, 1'b1);

        // Reset after 5 of 20 beats
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        do_run(12'd300, 13'd20, 5'd0, 1'b0);
        bad = 0;
        while (got_q.size() < 5 && bad < 200) begin
            @(negedge clk);
            bad++;
        end
        chk("midreset_reached_5", got_q.size() >= 5, 1);
        @(posedge clk);
        #1;
        reset        = 1'b1;
        model_active = 0;
        done_due     = 0;
        exp_q.delete();
        @(posedge clk);
        #1;
        check_reset_outputs("midreset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        d0 = done_seen;
        repeat (6) @(posedge clk);
        #1;
        chk("midreset_no_done", done_seen - d0, 0);
        do_run(12'd300, 13'd20, 5'd0, 1'b0);
        wait_idle(300);
        chk("after_reset_count", got_q.size(), 20);

        // Random runs under random backpressure
        rdy_mode = 2;
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 4096; i++) mem[i] = $urandom;
            clear_wr_log();
            rb = ADDR_W'($urandom);
            rl = (ADDR_W+1)'($urandom_range(1, 40));
            rs = 5'($urandom);
            rc = 1'($urandom);
            do_run(rb, rl, rs, rc);
            wait_idle(2000);
            chk("rand_count", got_q.size(), rl);
            check_cleared("rand", rb, int'(rl), rc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
